// File: rtl/hazard_pipe_if.sv
// Issue/forward/writeback bundle for hazard_pipe.
// The issue side (master) drives instruction and result data, and the tracker (slave) answers.
interface hazard_pipe_if #(
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32,
  parameter int unsigned NSRC = 2
);
  logic                 iss_valid;
  logic                 iss_we;
  logic                 iss_load;
  logic [AW-1:0]        iss_dst;
  logic [NSRC*AW-1:0]   iss_src;
  logic [NSRC-1:0]      iss_src_used;
  logic [DW-1:0]        alu_result;
  logic [DW-1:0]        mem_rdata;
  logic                 stall;
  logic [NSRC-1:0]      fwd_hit;
  logic [NSRC*DW-1:0]   fwd_data;
  logic                 wb_we;
  logic [AW-1:0]        wb_addr;
  logic [DW-1:0]        wb_data;

  modport master (
    output iss_valid, iss_we, iss_load, iss_dst, iss_src, iss_src_used, alu_result, mem_rdata,
    input  stall, fwd_hit, fwd_data, wb_we, wb_addr, wb_data
  );

  modport slave (
    input  iss_valid, iss_we, iss_load, iss_dst, iss_src, iss_src_used, alu_result, mem_rdata,
    output stall, fwd_hit, fwd_data, wb_we, wb_addr, wb_data
  );
endinterface

// File: rtl/hazard_pipe.sv
// DEPTH-stage in-flight instruction tracker: operand forwarding, load-use stall, and writeback.
// Legal ranges: DEPTH 2..8, NSRC 1..4.
module hazard_pipe #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32,
  parameter int unsigned NSRC  = 2
) (
  input logic         clk,
  input logic         rst,
  hazard_pipe_if.slave bus
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] we_q;
  logic [DEPTH-1:0] load_q;
  logic [AW-1:0]    dst_q  [DEPTH];
  logic [DW-1:0]    data_q [1:DEPTH-1];

  logic [DW-1:0]      stage_val [DEPTH];
  logic [NSRC-1:0]    found;
  logic [NSRC-1:0]    hit;
  logic [NSRC-1:0]    hazard;
  logic [NSRC*DW-1:0] fwd;
  logic               stall;

  // Stage 0 has no captured data yet; its value is the ALU output of this cycle.
  always_comb begin
    stage_val[0] = bus.alu_result;
    for (int k = 1; k < int'(DEPTH); k++) begin
      stage_val[k] = data_q[k];
    end
  end

  always_comb begin
    found  = '0;
    hit    = '0;
    hazard = '0;
    fwd    = '0;
    for (int s = 0; s < int'(NSRC); s++) begin
      if (bus.iss_src_used[s] && (bus.iss_src[s*AW +: AW] != '0)) begin
        // Ascending search with a found latch, so the youngest producer wins.
        for (int k = 0; k < int'(DEPTH); k++) begin
          if (!found[s] && valid_q[k] && we_q[k] && (dst_q[k] == bus.iss_src[s*AW +: AW])) begin
            found[s] = 1'b1;
            if (!load_q[k]) begin
              hit[s]            = 1'b1;
              fwd[s*DW +: DW]   = stage_val[k];
            end else if (k == int'(DEPTH) - 1) begin
              hit[s]            = 1'b1;
              fwd[s*DW +: DW]   = bus.mem_rdata;
            end else begin
              hazard[s]         = 1'b1;
            end
          end
        end
      end
    end
  end

  assign stall        = bus.iss_valid & (|hazard);
  assign bus.stall    = stall;
  assign bus.fwd_hit  = hit;
  assign bus.fwd_data = fwd;

  assign bus.wb_we   = valid_q[DEPTH-1] & we_q[DEPTH-1] & (dst_q[DEPTH-1] != '0);
  assign bus.wb_addr = dst_q[DEPTH-1];
  assign bus.wb_data = load_q[DEPTH-1] ? bus.mem_rdata : data_q[DEPTH-1];

  // Only the valid bits are reset; the payload is qualified by them.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= {valid_q[DEPTH-2:0], bus.iss_valid & ~stall};
    end
  end

  always_ff @(posedge clk) begin
    we_q      <= {we_q[DEPTH-2:0], bus.iss_we};
    load_q    <= {load_q[DEPTH-2:0], bus.iss_load};
    dst_q[0]  <= bus.iss_dst;
    data_q[1] <= bus.alu_result;
    for (int k = 1; k < int'(DEPTH); k++) begin
      dst_q[k] <= dst_q[k-1];
    end
    for (int k = 2; k < int'(DEPTH); k++) begin
      data_q[k] <= data_q[k-1];
    end
  end

endmodule

// File: tb/tb_hazard_pipe.sv
// Self-checking bench for hazard_pipe: a DEPTH=3/NSRC=2 instance driven from a vector table with
// a writeback scoreboard, plus a DEPTH=5/NSRC=3 instance for the deep corner cases.
module tb_hazard_pipe;

  localparam logic [31:0] Mem = 32'hCAFEF00D;

  typedef struct {
    logic        v, we, ld;
    logic [4:0]  dst, s0, s1;
    logic [1:0]  used;
    logic [31:0] alu;
    logic        xs;
    logic [1:0]  xh;
    logic [31:0] xf0, xf1;
  } vec_t;

  typedef struct {
    int          due;
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];
  wb_t  sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hazard_pipe_if #(.AW(5), .DW(32), .NSRC(2)) bus3 ();
  hazard_pipe_if #(.AW(5), .DW(32), .NSRC(3)) bus5 ();

  hazard_pipe #(.DEPTH(3), .AW(5), .DW(32), .NSRC(2)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));
  hazard_pipe #(.DEPTH(5), .AW(5), .DW(32), .NSRC(3)) u_dut5 (.clk(clk), .rst(rst), .bus(bus5));

  task automatic chk(input string nm, input int idx, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s #%0d got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input int v, we, ld, dst, s0, s1, used, input logic [31:0] alu,
                              input int xs, xh, input logic [31:0] xf0, xf1);
    vec_t r;
    r.v = 1'(v); r.we = 1'(we); r.ld = 1'(ld);
    r.dst = 5'(dst); r.s0 = 5'(s0); r.s1 = 5'(s1); r.used = 2'(used);
    r.alu = alu; r.xs = 1'(xs); r.xh = 2'(xh); r.xf0 = xf0; r.xf1 = xf1;
    return r;
  endfunction

  task automatic apply3(input vec_t t);
    bus3.iss_valid    = t.v;
    bus3.iss_we       = t.we;
    bus3.iss_load     = t.ld;
    bus3.iss_dst      = t.dst;
    bus3.iss_src      = {t.s1, t.s0};
    bus3.iss_src_used = t.used;
    bus3.alu_result   = t.alu;
  endtask

  // nxt_alu is the ALU value driven next cycle, i.e. this instruction's result if it issues.
  task automatic check3(input vec_t t, input int idx, input logic [31:0] nxt_alu);
    wb_t e;
    chk("stall", idx, bus3.stall, t.xs);
    chk("fwd_hit", idx, bus3.fwd_hit, t.xh);
    chk("fwd_data", idx, bus3.fwd_data, {t.xf1, t.xf0});
    if (t.v && !t.xs && t.we && (t.dst != 5'd0)) begin
      e.due = cyc + 3; e.addr = t.dst; e.data = t.ld ? Mem : nxt_alu;
      sb.push_back(e);
    end
  endtask

  task automatic cyc3(input vec_t t, input int idx, input logic [31:0] nxt_alu);
    @(negedge clk);
    apply3(t);
    #1;
    check3(t, idx, nxt_alu);
  endtask

  task automatic drv5(input int v, we, ld, dst, input logic [14:0] src, input logic [2:0] used,
                      input logic [31:0] alu);
    @(negedge clk);
    bus5.iss_valid    = 1'(v);
    bus5.iss_we       = 1'(we);
    bus5.iss_load     = 1'(ld);
    bus5.iss_dst      = 5'(dst);
    bus5.iss_src      = src;
    bus5.iss_src_used = used;
    bus5.alu_result   = alu;
    #1;
  endtask

  // Writeback monitor for the DEPTH=3 instance.
  always @(negedge clk) begin
    wb_t e;
    #2;
    if (!rst) begin
      if (bus3.wb_we) begin
        if (sb.size() == 0) begin
          chk("wb_we_unexpected", cyc, bus3.wb_we, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("wb_cycle", cyc, cyc, e.due);
          chk("wb_addr", cyc, bus3.wb_addr, e.addr);
          chk("wb_data", cyc, bus3.wb_data, e.data);
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk("wb_we_missing", e.due, bus3.wb_we, 1'b1);
      end
    end
  end

  initial begin
    vec_t rd;
    apply3(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    bus3.mem_rdata = Mem;
    bus5.mem_rdata = Mem;
    bus5.iss_valid = 1'b0; bus5.iss_we = 1'b0; bus5.iss_load = 1'b0; bus5.iss_dst = '0;
    bus5.iss_src = '0; bus5.iss_src_used = '0; bus5.alu_result = '0;

    //      v we ld dst s0 s1 used alu           xs xh xf0           xf1
    tbl.push_back(mk(1, 1, 0, 3,  0,  0, 0, 32'h0,     0, 0, 32'h0,    32'h0));
    tbl.push_back(mk(1, 1, 0, 10, 3,  0, 1, 32'h1234,  0, 1, 32'h1234, 32'h0));
    tbl.push_back(mk(1, 0, 0, 0,  3, 10, 3, 32'h5555,  0, 3, 32'h1234, 32'h5555));
    tbl.push_back(mk(0, 0, 0, 0,  0,  0, 0, 32'h0,     0, 0, 32'h0,    32'h0));
    tbl.push_back(mk(1, 1, 1, 5,  0,  0, 0, 32'h0,     0, 0, 32'h0,    32'h0));
    tbl.push_back(mk(1, 1, 0, 6,  5,  0, 1, 32'hDEAD,  1, 0, 32'h0,    32'h0));
    tbl.push_back(mk(1, 1, 0, 6,  5,  0, 1, 32'hDEAD,  1, 0, 32'h0,    32'h0));
    tbl.push_back(mk(1, 1, 0, 6,  5,  0, 1, 32'hDEAD,  0, 1, Mem,      32'h0));
    tbl.push_back(mk(1, 1, 0, 7,  0,  0, 0, 32'h66,    0, 0, 32'h0,    32'h0));
    tbl.push_back(mk(1, 1, 0, 7,  0,  0, 0, 32'h11,    0, 0, 32'h0,    32'h0));
    tbl.push_back(mk(1, 0, 0, 0,  7,  6, 3, 32'h22,    0, 3, 32'h22,   32'h66));
    tbl.push_back(mk(1, 1, 0, 0,  0,  0, 0, 32'h0,     0, 0, 32'h0,    32'h0));
    tbl.push_back(mk(1, 0, 0, 0,  0,  7, 3, 32'hFFFF,  0, 2, 32'h0,    32'h22));
    tbl.push_back(mk(1, 0, 0, 0,  7,  7, 0, 32'h0,     0, 0, 32'h0,    32'h0));
    tbl.push_back(mk(0, 0, 0, 0,  0,  0, 0, 32'h0,     0, 0, 32'h0,    32'h0));
    tbl.push_back(mk(1, 1, 1, 8,  0,  0, 0, 32'h0,     0, 0, 32'h0,    32'h0));
    tbl.push_back(mk(1, 0, 0, 0,  8,  8, 0, 32'h0,     0, 0, 32'h0,    32'h0));
    tbl.push_back(mk(1, 0, 0, 0,  0,  8, 2, 32'h0,     1, 0, 32'h0,    32'h0));
    tbl.push_back(mk(1, 0, 0, 0,  0,  8, 2, 32'h0,     0, 2, 32'h0,    Mem));
    tbl.push_back(mk(0, 0, 0, 0,  0,  0, 0, 32'h0,     0, 0, 32'h0,    32'h0));

    // An instruction presented during reset must be discarded.
    repeat (2) @(negedge clk);
    apply3(mk(1, 1, 0, 12, 0, 0, 0, 32'h0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    rd = mk(1, 0, 0, 0, 12, 0, 1, 32'hBEEF, 0, 0, 32'h0, 32'h0);
    apply3(rd);
    #1;
    check3(rd, 900, 32'h0);
    chk("rst_wb_we", 900, bus3.wb_we, 1'b0);
    chk("rst_wb_we5", 900, bus5.wb_we, 1'b0);
    chk("rst_stall5", 900, bus5.stall, 1'b0);
    chk("rst_hit5", 900, bus5.fwd_hit, 3'b000);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc3(tbl[i], i, (i + 1 < tbl.size()) ? tbl[i+1].alu : 32'h0);
    end
    repeat (4) cyc3(tbl[tbl.size()-1], 99, 32'h0);

    // Mid-flight reset flushes three writers.
    cyc3(mk(1, 1, 0, 1, 0, 0, 0, 32'h0,  0, 0, 0, 0), 101, 32'hA1);
    cyc3(mk(1, 1, 0, 2, 0, 0, 0, 32'hA1, 0, 0, 0, 0), 102, 32'hA2);
    cyc3(mk(1, 1, 0, 3, 0, 0, 0, 32'hA2, 0, 0, 0, 0), 103, 32'hA3);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    apply3(mk(0, 0, 0, 0, 0, 0, 0, 32'hA3, 0, 0, 0, 0));
    rd = mk(1, 0, 0, 0, 1, 2, 3, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    apply3(rd);
    #1;
    check3(rd, 110, 32'h0);
    chk("flush_wb_we", 110, bus3.wb_we, 1'b0);
    for (int i = 1; i < 3; i++) begin
      cyc3(mk(1, 0, 0, 0, 3, 2, 3, 32'h0, 0, 0, 0, 0), 110 + i, 32'h0);
      chk("flush_wb_we", 110 + i, bus3.wb_we, 1'b0);
    end

    // DEPTH=5, NSRC=3: load r9 reaches stage 2 while r4 sits in stage 1.
    drv5(1, 1, 1, 9, 15'd0, 3'b000, 32'h0);
    drv5(1, 1, 0, 4, 15'd0, 3'b000, 32'h0);
    drv5(0, 0, 0, 0, 15'd0, 3'b000, 32'h44);
    drv5(1, 0, 0, 0, {5'd0, 5'd9, 5'd4}, 3'b111, 32'h0);
    chk("d5_stall_a", 200, bus5.stall, 1'b1);
    chk("d5_hit_a", 200, bus5.fwd_hit, 3'b001);
    chk("d5_fwd_a", 200, bus5.fwd_data, {32'h0, 32'h0, 32'h44});
    drv5(1, 0, 0, 0, {5'd0, 5'd9, 5'd4}, 3'b111, 32'h0);
    chk("d5_stall_b", 201, bus5.stall, 1'b1);
    drv5(1, 0, 0, 0, {5'd0, 5'd9, 5'd4}, 3'b111, 32'h0);
    chk("d5_stall_c", 202, bus5.stall, 1'b0);
    chk("d5_hit_c", 202, bus5.fwd_hit, 3'b011);
    chk("d5_fwd_c", 202, bus5.fwd_data, {32'h0, Mem, 32'h44});
    chk("d5_wb_we_ld", 202, bus5.wb_we, 1'b1);
    chk("d5_wb_addr_ld", 202, bus5.wb_addr, 5'd9);
    chk("d5_wb_data_ld", 202, bus5.wb_data, Mem);
    drv5(0, 0, 0, 0, 15'd0, 3'b000, 32'h0);
    chk("d5_wb_we_alu", 203, bus5.wb_we, 1'b1);
    chk("d5_wb_addr_alu", 203, bus5.wb_addr, 5'd4);
    chk("d5_wb_data_alu", 203, bus5.wb_data, 32'h44);

    // Youngest wins with the older producer in stage 3.
    drv5(1, 1, 0, 7, 15'd0, 3'b000, 32'h0);
    drv5(0, 0, 0, 0, 15'd0, 3'b000, 32'h11);
    drv5(1, 1, 0, 7, 15'd0, 3'b000, 32'h0);
    drv5(0, 0, 0, 0, 15'd0, 3'b000, 32'h22);
    drv5(1, 0, 0, 0, {5'd0, 5'd0, 5'd7}, 3'b001, 32'h0);
    chk("d5_young_stall", 210, bus5.stall, 1'b0);
    chk("d5_young_hit", 210, bus5.fwd_hit, 3'b001);
    chk("d5_young_fwd", 210, bus5.fwd_data, {32'h0, 32'h0, 32'h22});
    drv5(0, 0, 0, 0, 15'd0, 3'b000, 32'h0);

    repeat (8) @(negedge clk);
    #3;
    chk("sb_drained", 0, sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_pipe.md
# hazard_pipe

Parametrised in-flight instruction tracker for the pipelined MIPS core. It generalises the fixed 2-deep destination, write-enable and load shift registers into a DEPTH-stage tracked pipeline. It adds per-source forwarding, load-use stall generation and a single writeback port. It sits between control/decode (issue side), the ALU (result side) and the register file (writeback side).

## Interface
- DEPTH, 3: stages from issue to writeback; legal range 2..8.
- AW, 5: register address width.
- DW, 32: data width.
- NSRC, 2: number of source operands checked per issued instruction; legal range 1..4.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- iss_valid  in  1  instruction presented for issue.
- iss_we  in  1  instruction writes a register.
- iss_load  in  1  result comes from memory, not the ALU.
- iss_dst  in  AW  destination register.
- iss_src  in  NSRC*AW  source registers; source s is bits [s*AW +: AW].
- iss_src_used  in  NSRC  bit s set means source s is read.
- alu_result  in  DW  ALU result for the entry currently in stage 0.
- mem_rdata  in  DW  load data for the entry currently in stage DEPTH-1.
- stall  out  1  issue refused this cycle; the issue side holds its inputs.
- fwd_hit  out  NSRC  bit s set means fwd_data lane s replaces the register-file value.
- fwd_data  out  NSRC*DW  forwarded operand per source.
- wb_we  out  1  register-file write enable.
- wb_addr  out  AW  register-file write address.
- wb_data  out  DW  register-file write data.

## Operation
- Pipeline state per stage k (0..DEPTH-1): valid, we, load, dst, data. The data field is meaningful only for k ≥ 1 and non-load entries.
- The pipeline advances every cycle with no freeze. On each edge, stage k moves to stage k+1 and the entry in stage DEPTH-1 retires.
- Stage 0 load on each edge:
  - Issued instruction when iss_valid & !stall.
  - Bubble (valid=0) otherwise.
- Data capture: alu_result is captured into stage 1 data as stage 0 advances.
- Writeback, combinational from stage DEPTH-1:
  - wb_we = valid & we & (dst != 0).
  - wb_addr = dst.
  - wb_data = load ? mem_rdata : data.
- Forward search for each source s with iss_src_used[s] and iss_src[s] != 0:
  - Candidate matches are valid & we entries with dst == iss_src[s].
  - Stages are searched youngest first, stage 0 then 1 upward; only the youngest match is used.
- Youngest match resolution:
  - Non-load in stage 0: hit, value = alu_result.
  - Non-load in stage 1..DEPTH-1: hit, value = that stage's data.
  - Load in stage DEPTH-1: hit, value = mem_rdata.
  - Load in stage < DEPTH-1: hazard on source s.
- stall = iss_valid & (hazard on any source).
- fwd_hit and fwd_data are driven regardless of stall. Consumers ignore them while stall=1.
- Register 0 is never forwarded, never hazards and never written.
- Unused sources (iss_src_used[s]=0) give fwd_hit[s]=0 and no hazard.
- fwd_data lanes with fwd_hit[s]=0 are driven to 0.

## Timing
- Reset: on an edge with rst=1, every stage valid is cleared; data fields are don't-care.
- Next cycle after reset: wb_we=0, stall=0, fwd_hit=0. The instruction presented in the rst cycle is discarded, not issued.
- Reset mid-operation flushes all in-flight entries; no writeback occurs for them.
- Issue-to-writeback latency: an instruction issued in cycle t has wb_we asserted in cycle t+DEPTH.
- Forwarding paths are combinational, same cycle as issue. All state changes occur on the clock edge only.
- Load-use: a consumer issued right after a load stalls for DEPTH-1 cycles.
- Same-cycle writeback and read of a register: forwarding covers it, so the register file needs no internal bypass.
- Throughput: one issue per cycle when there is no load hazard.

## Test plan
- ALU back-to-back, DEPTH=3: issue r3 ← (alu_result=0x1234); next cycle issue with src0=r3 → stall=0, fwd_hit=01, fwd_data lane0=0x1234; wb_we=1, wb_addr=3 three cycles after the first issue.
- Load-use, DEPTH=3: issue load r5; next cycle issue using r5 → stall=1 for 2 cycles; then fwd_hit=01 with fwd_data lane0=mem_rdata (0xCAFEF00D); the consumer enters stage 0 in that cycle.
- Youngest wins: issue r7 ← 0x11, then r7 ← 0x22, then a reader of r7 → fwd_data lane0=0x22. DEPTH=4 variant with the older producer in stage 3 gives the same result.
- Register zero: issue dst=r0 with alu_result=0xFFFF, then a reader with src0=r0 → fwd_hit=0, no stall; wb_we stays 0 at retirement.
- Reset mid-flight: issue 3 writers, assert rst for 1 cycle → wb_we=0 for the next DEPTH cycles, stall=0, fwd_hit=0.
- NSRC=3, DEPTH=5: pending load on r9 at stage 2 plus a non-load r4 at stage 1; issue with srcs {r4, r9, r0} → stall=1, fwd_hit=001. Two cycles later: stall=0, fwd_hit=011.
